// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage pipeline. It generates the
//   stall and flush controls for the F/D, D/E and E/M pipeline registers and
//   the select lines for the Execute-stage forwarding muxes. It handles:
//     - load-use hazards (one bubble inserted into Execute)
//     - taken branch/jump flushes resolved in Execute
//     - multi-cycle data-memory waits, supervised by a timeout watchdog that
//       parks the core in a sticky FAULT state
//
// Optional feature macro: HAZARD_PERF_EN
//   When defined, the performance counters PerfStallCnt and PerfFlushCnt are
//   added as outputs.
//
// Ports
//   clk, rst               clock and synchronous active-high reset
//   Rs1D, Rs2D             source registers of the instruction in Decode
//   Rs1E, Rs2E, RdE        source and destination registers in Execute
//   ResultSrcE0            the Execute instruction is a load
//   PCSrcE                 taken branch/jump resolved in Execute
//   RdM, RegWriteM         destination register / write enable in Memory
//   RdW, RegWriteW         destination register / write enable in Writeback
//   MemReqM, MemReadyM     data-memory request / completion in Memory
//   StallF..StallM         hold the PC, F/D, D/E and E/M registers
//   FlushD, FlushE         turn the F/D or D/E register into a bubble
//   ForwardAE, ForwardBE   forwarding select: 00 RF, 01 from W, 10 from M
//   Fault                  sticky memory-timeout flag
//   PerfStallCnt/FlushCnt  (HAZARD_PERF_EN only) stall and flush cycle counts
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  ResultSrcE0,
  input  logic                  PCSrcE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           PerfStallCnt,
  output logic [31:0]           PerfFlushCnt,
`endif
  output logic                  Fault
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;

  state_t                state_reg, state_next;
  logic [TIMEOUT_W-1:0]  wait_cnt_reg, wait_cnt_next;

  logic lw_stall;
  logic mem_wait;

  assign lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_wait = MemReqM && !MemReadyM && (state_reg != FAULT);

  // ---------------------------------------------------------------------------
  // Forwarding: the Memory stage holds the younger result, so it wins over W.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state. A withdrawn request (MemReqM dropping without ready) is treated
  // like a completion: the pipeline simply resumes.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (mem_wait) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = TIMEOUT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM || !MemReqM) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else begin
          if (wait_cnt_reg != CNT_MAX)
            wait_cnt_next = wait_cnt_reg + 1'b1;
          if (wait_cnt_reg >= CNT_LAST)
            state_next = FAULT;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline controls. Priority: reset > fault > memory wait > taken branch >
  // load-use. A branch held in Execute during a memory wait is frozen rather
  // than flushed, so it is acted on once the wait finishes.
  // ---------------------------------------------------------------------------
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (state_reg == FAULT || mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      // Any load-use hazard here belongs to a wrong-path instruction.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign Fault = (state_reg == FAULT);

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (StallF)
        perf_stall_reg <= perf_stall_reg + 32'd1;
      if (FlushD)
        perf_flush_reg <= perf_flush_reg + 32'd1;
    end
  end

  assign PerfStallCnt = perf_stall_reg;
  assign PerfFlushCnt = perf_flush_reg;
`endif

endmodule
